// File: rtl/spram_ctrl.sv
// spram_ctrl: requester-side controller for a single-port RAM wrapper.
//
// The client issues requests on a valid/ready channel and receives read data
// on a valid/ready response channel. The RAM's fixed read latency is tracked
// with a LATENCY-deep in-flight tag pipe. Read data lands in an in-order
// response FIFO of depth LATENCY+1. A credit counter bounds the number of
// outstanding reads so that this FIFO can never overflow, which lets the
// client stall responses safely.
//
// Optional feature, macro SPRAM_CTRL_CLEAR_EN:
//   When defined, the controller clears every RAM entry to CLEAR_VALUE after
//   reset: one IDLE cycle, then DEPTH CLEAR cycles, then RUN.
//   When undefined, the controller resets straight into RUN.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   req_valid/ready   request handshake; req_we selects write (1) or read (0)
//   req_addr/wdata    request address and write data
//   resp_valid/ready  read-response handshake; resp_rdata is the FIFO head
//   init_done         high while the controller is in RUN
//   ram_en/we/addr/din  RAM pins, driven by the controller
//   ram_dout          RAM read data, valid LATENCY cycles after a read
module spram_ctrl #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           DEPTH       = 128,
    parameter int unsigned           LATENCY     = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [$clog2(DEPTH)-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     init_done,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [$clog2(DEPTH)-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    input  logic [DATA_WIDTH-1:0]    ram_dout
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned FIFO_D = LATENCY + 1;
    localparam int unsigned IDX_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int unsigned CRED_W = $clog2(LATENCY + 2);

    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(LATENCY + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FIFO_D - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              r_state;
    logic [CRED_W-1:0]   r_credits;
    logic [LATENCY-1:0]  r_pipe;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_D];
    logic [IDX_W-1:0]    r_wr_idx;
    logic [IDX_W-1:0]    r_rd_idx;
    logic                r_wr_lap;
    logic                r_rd_lap;

    logic w_run;
    logic w_accept;
    logic w_rd_acc;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

`ifdef SPRAM_CTRL_CLEAR_EN
    logic [ADDR_W-1:0] r_cnt;

    // Init sequencer: one IDLE cycle, sweep every address once, then RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_CLEAR;
                ST_CLEAR: begin
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end
`else
    // Without the clear sweep the controller is usable straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= ST_RUN;
        end
    end
`endif

    assign w_run     = (r_state == ST_RUN);
    assign init_done = w_run;
    // Reset gates ready directly so nothing is accepted while rst is low.
    assign req_ready = rst && w_run && (r_credits != '0);
    assign w_accept  = req_valid && req_ready;
    assign w_rd_acc  = w_accept && !req_we;

    // RAM pin mux: clear sweep during CLEAR, pass-through of the request in RUN.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = CLEAR_VALUE;
        if (w_run) begin
            ram_en   = w_accept;
            ram_we   = w_accept && req_we;
            ram_addr = req_addr;
            ram_din  = req_wdata;
        end
`ifdef SPRAM_CTRL_CLEAR_EN
        else if (r_state == ST_CLEAR) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = r_cnt;
            ram_din  = CLEAR_VALUE;
        end
`endif
    end

    // In-flight tags: a read tag exits when its ram_dout is valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_rd_acc;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_push     = r_pipe[LATENCY-1];
    assign w_empty    = (r_wr_idx == r_rd_idx) && (r_wr_lap == r_rd_lap);
    assign w_full     = (r_wr_idx == r_rd_idx) && (r_wr_lap != r_rd_lap);
    assign resp_valid = !w_empty;
    assign resp_rdata = r_mem[r_rd_idx];
    assign w_pop      = resp_valid && resp_ready;

    // Response FIFO pointers; indices wrap at FIFO_D, lap bit flips on wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_idx <= '0;
            r_wr_lap <= 1'b0;
            r_rd_idx <= '0;
            r_rd_lap <= 1'b0;
        end else begin
            if (w_push) begin
                if (r_wr_idx == IDX_LAST) begin
                    r_wr_idx <= '0;
                    r_wr_lap <= ~r_wr_lap;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end
            if (w_pop) begin
                if (r_rd_idx == IDX_LAST) begin
                    r_rd_idx <= '0;
                    r_rd_lap <= ~r_rd_lap;
                end else begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
            end
        end
    end

    // Response storage; holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_idx] <= ram_dout;
        end
    end

    // Credits: one per free FIFO slot not already claimed by an in-flight read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credits <= CRED_MAX;
        end else if (w_rd_acc && !w_pop) begin
            r_credits <= r_credits - 1'b1;
        end else if (w_pop && !w_rd_acc) begin
            r_credits <= r_credits + 1'b1;
        end
    end

    // Credit accounting must keep the FIFO from overflowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(w_push && w_full));
            assert (r_credits <= CRED_MAX);
        end
    end

endmodule

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl: randomized bench for spram_ctrl with a write-first RAM model
// and a transaction-level reference (memory array + expected-response queue).
module tb_spram_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int LAT   = 1;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;
    logic          init_done;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    spram_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .LATENCY    (LAT),
        .CLEAR_VALUE('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .init_done (init_done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Write-first single-port RAM, read latency 1.
    logic [DW-1:0] tb_ram [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                tb_ram[ram_addr] <= ram_din;
                ram_dout         <= ram_din;
            end else begin
                ram_dout <= tb_ram[ram_addr];
            end
        end
    end

    int            n_err = 0;
    int            n_chk = 0;
    int            cyc = 0;
    int            outstanding = 0;
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_data [$];
    int            exp_time [$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One RUN-mode cycle: drive, check at negedge against the model, update model.
    task automatic drive_cycle(input logic v, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic rr, output logic acc);
        logic exp_ready;
        logic exp_rv;
        req_valid  = v;
        req_we     = we;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = rr;
        @(negedge clk);
        exp_ready = (outstanding < LAT + 1);
        exp_rv    = (exp_data.size() != 0) && (exp_time[0] <= cyc);
        chk("init_done", init_done, 1);
        chk("req_ready", req_ready, exp_ready);
        chk("resp_valid", resp_valid, exp_rv);
        if (exp_rv) chk("resp_rdata", resp_rdata, exp_data[0]);
        acc = v && exp_ready;
        chk("ram_en", ram_en, acc);
        if (acc) begin
            chk("ram_we", ram_we, we);
            chk("ram_addr", ram_addr, a);
            if (we) chk("ram_din", ram_din, d);
        end
        if (exp_rv && rr) begin
            void'(exp_data.pop_front());
            void'(exp_time.pop_front());
            outstanding--;
        end
        if (acc) begin
            if (we) begin
                model_mem[a] = d;
            end else begin
                exp_data.push_back(model_mem[a]);
                exp_time.push_back(cyc + LAT + 1);
                outstanding++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);
    endtask

    // Hold reset, check reset values, release, and follow the clear sweep.
    task automatic apply_reset();
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_ram_en", ram_en, 0);
`ifdef SPRAM_CTRL_CLEAR_EN
        chk("rst_init_done", init_done, 0);
`else
        chk("rst_init_done", init_done, 1);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_data.delete();
        exp_time.delete();
        outstanding = 0;
`ifdef SPRAM_CTRL_CLEAR_EN
        @(negedge clk);
        chk("idle_ram_en", ram_en, 0);
        chk("idle_init_done", init_done, 0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("clr_ram_en", ram_en, 1);
            chk("clr_ram_we", ram_we, 1);
            chk("clr_ram_addr", ram_addr, i);
            chk("clr_ram_din", ram_din, 0);
            chk("clr_init_done", init_done, 0);
            chk("clr_req_ready", req_ready, 0);
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        @(posedge clk);
        #1;
`endif
    endtask

    initial begin
        logic acc;

        apply_reset();

`ifndef SPRAM_CTRL_CLEAR_EN
        // Contents are undefined without the clear; define them first.
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b1, AW'(i), $urandom, 1'b1, acc);
`endif

        // Read of an address not written since init.
        drive_cycle(1'b1, 1'b0, AW'(7), '0, 1'b1, acc);
        idle(3);

        // Write then read-back in the next cycle.
        drive_cycle(1'b1, 1'b1, AW'(5), 32'hDEADBEEF, 1'b1, acc);
        drive_cycle(1'b1, 1'b0, AW'(5), '0, 1'b1, acc);
        idle(4);

        // Stalled responses exhaust credits; third read waits for the first pop.
        drive_cycle(1'b1, 1'b1, AW'(1), 32'h11, 1'b1, acc);
        drive_cycle(1'b1, 1'b1, AW'(2), 32'h22, 1'b1, acc);
        drive_cycle(1'b1, 1'b1, AW'(3), 32'h33, 1'b1, acc);
        drive_cycle(1'b1, 1'b0, AW'(1), '0, 1'b0, acc);
        drive_cycle(1'b1, 1'b0, AW'(2), '0, 1'b0, acc);
        drive_cycle(1'b1, 1'b0, AW'(3), '0, 1'b0, acc);
        drive_cycle(1'b1, 1'b0, AW'(3), '0, 1'b0, acc);
        acc = 1'b0;
        for (int t = 0; t < 8 && !acc; t++) drive_cycle(1'b1, 1'b0, AW'(3), '0, 1'b1, acc);
        idle(4);

        // Randomized traffic with bursty response back-pressure.
        for (int n = 0; n < 1500; n++) begin
            logic          v;
            logic          we;
            logic          rr;
            logic [AW-1:0] a;
            v  = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1) == 1;
            rr = ($urandom_range(0, 2) != 0);
            a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                             : AW'($urandom_range(0, 15));
            drive_cycle(v, we, a, $urandom, rr, acc);
        end
        idle(6);

        // Reset right after a read accept discards everything in flight.
        drive_cycle(1'b1, 1'b0, AW'(5), '0, 1'b1, acc);
        rst = 1'b0;
        #1;
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_ram_en", ram_en, 0);
        apply_reset();
        idle(4);

        // Top address write/read.
        drive_cycle(1'b1, 1'b1, AW'(127), 32'hCAFEF00D, 1'b1, acc);
        drive_cycle(1'b1, 1'b0, AW'(127), '0, 1'b1, acc);
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
